kc705_loopback_reset_seq: RTL and testbench



---
 rtl/kc705_loopback_reset_seq.sv | 120 ++++++++++++
 tb/tb_kc705_loopback_reset_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/kc705_loopback_reset_seq.sv
// Reset sequencer for the KC705 loopback clock generator.
//
// This block pulses the MMCM reset and then waits for the MMCM lock. The lock must
// stay high for a stable window before the downstream system reset is released.
// If lock never arrives, the MMCM is pulsed again. If lock is lost while running,
// the MMCM is pulsed again and the system reset is reasserted.
//
// Ports:
//   clk           free-running reference clock, not derived from the MMCM
//   rst           synchronous active-high reset
//   mmcm_locked   raw MMCM lock, asynchronous to clk
//   mmcm_rst      active-high reset to the MMCM
//   sys_rst       active-high downstream system reset
//   ready         high only while running
//   state_o       current state (0 MMCM reset, 1 wait lock, 2 stable, 3 run)
//   timeout_count saturating count of lock timeouts
//   relock_count  saturating count of lock losses while running
module kc705_loopback_reset_seq #(
    parameter int unsigned MMCM_RST_CYCLES     = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned CNT_WIDTH           = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mmcm_locked,
    output logic                 mmcm_rst,
    output logic                 sys_rst,
    output logic                 ready,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] timeout_count,
    output logic [CNT_WIDTH-1:0] relock_count
);

    typedef enum logic [1:0] {
        StMmcmReset = 2'd0,
        StWaitLock  = 2'd1,
        StStable    = 2'd2,
        StRun       = 2'd3
    } state_e;

    localparam logic [31:0] RstLast     = 32'(MMCM_RST_CYCLES - 1);
    localparam logic [31:0] StableLast  = 32'(LOCK_STABLE_CYCLES - 1);
    localparam logic [31:0] TimeoutLast = 32'(LOCK_TIMEOUT_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [31:0]            cnt_q;
    logic                   sync1_q, locked_s_q;
    logic                   mmcm_rst_q, sys_rst_q, ready_q;
    logic [CNT_WIDTH-1:0]   timeout_q, relock_q;
    logic                   timeout_inc, relock_inc;

    // Next-state decision; lock takes priority over timeout in WAIT_LOCK.
    always_comb begin
        state_d     = state_q;
        timeout_inc = 1'b0;
        relock_inc  = 1'b0;
        unique case (state_q)
            StMmcmReset: begin
                if (cnt_q == RstLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (locked_s_q) begin
                    state_d = StStable;
                end else if (cnt_q == TimeoutLast) begin
                    state_d     = StMmcmReset;
                    timeout_inc = 1'b1;
                end
            end
            StStable: begin
                if (!locked_s_q) begin
                    state_d = StWaitLock;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!locked_s_q) begin
                    state_d    = StMmcmReset;
                    relock_inc = 1'b1;
                end
            end
            default: state_d = StMmcmReset;
        endcase
    end

    // Outputs are decoded from state_d, so each one already reflects the state
    // entered on this edge while still coming straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
            state_q    <= StMmcmReset;
            cnt_q      <= 32'd0;
            mmcm_rst_q <= 1'b1;
            sys_rst_q  <= 1'b1;
            ready_q    <= 1'b0;
            timeout_q  <= '0;
            relock_q   <= '0;
        end else begin
            sync1_q    <= mmcm_locked;
            locked_s_q <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= (state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
            mmcm_rst_q <= (state_d == StMmcmReset);
            sys_rst_q  <= (state_d != StRun);
            ready_q    <= (state_d == StRun);
            if (timeout_inc && (timeout_q != '1)) timeout_q <= timeout_q + CNT_WIDTH'(1);
            if (relock_inc && (relock_q != '1))   relock_q  <= relock_q + CNT_WIDTH'(1);
        end
    end

    assign mmcm_rst      = mmcm_rst_q;
    assign sys_rst       = sys_rst_q;
    assign ready         = ready_q;
    assign state_o       = state_q;
    assign timeout_count = timeout_q;
    assign relock_count  = relock_q;

endmodule

// File: tb/tb_kc705_loopback_reset_seq.sv
// Testbench for kc705_loopback_reset_seq.
//
// A behavioural model runs alongside the DUT and is compared every cycle.
// The model tracks the raw lock history and the time spent in each phase.
// Directed scenarios also measure the key latencies and the pulse widths.
module tb_kc705_loopback_reset_seq;

    localparam int unsigned RstCyc = 4;
    localparam int unsigned StbCyc = 8;
    localparam int unsigned TmoCyc = 32;
    localparam int unsigned CntW   = 8;
    localparam int          SatMax = 255;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mmcm_locked = 1'b0;
    logic            mmcm_rst, sys_rst, ready;
    logic [1:0]      state_o;
    logic [CntW-1:0] timeout_count, relock_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase 0 MMCM reset, 1 wait lock, 2 stable, 3 run.
    int m_phase;
    int m_dwell;     // edges already spent in the current phase
    int m_tmo, m_rel;
    bit m_hist[2];   // [0] lock seen one edge ago, [1] lock seen two edges ago

    kc705_loopback_reset_seq #(
        .MMCM_RST_CYCLES    (RstCyc),
        .LOCK_STABLE_CYCLES (StbCyc),
        .LOCK_TIMEOUT_CYCLES(TmoCyc),
        .CNT_WIDTH          (CntW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mmcm_locked  (mmcm_locked),
        .mmcm_rst     (mmcm_rst),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .state_o      (state_o),
        .timeout_count(timeout_count),
        .relock_count (relock_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit l);
        bit seen;
        int nxt;
        if (r) begin
            m_phase = 0; m_dwell = 0; m_tmo = 0; m_rel = 0;
            m_hist[0] = 1'b0; m_hist[1] = 1'b0;
        end else begin
            seen = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = l;
            nxt = m_phase;
            case (m_phase)
                0: if (m_dwell + 1 >= RstCyc) nxt = 1;
                1: if (seen) nxt = 2;
                   else if (m_dwell + 1 >= TmoCyc) begin
                       nxt = 0;
                       if (m_tmo < SatMax) m_tmo++;
                   end
                2: if (!seen) nxt = 1;
                   else if (m_dwell + 1 >= StbCyc) nxt = 3;
                default: if (!seen) begin
                       nxt = 0;
                       if (m_rel < SatMax) m_rel++;
                   end
            endcase
            m_dwell = (nxt == m_phase) ? m_dwell + 1 : 0;
            m_phase = nxt;
        end
    endtask

    // One clock edge: advance the model with the inputs the DUT sampled, then compare.
    task automatic step();
        bit r, l;
        r = rst;
        l = mmcm_locked;
        @(posedge clk);
        model_edge(r, l);
        #1;
        check_eq("state", int'(state_o), m_phase);
        check_eq("mmcm_rst", int'(mmcm_rst), int'(m_phase == 0));
        check_eq("sys_rst", int'(sys_rst), int'(m_phase != 3));
        check_eq("ready", int'(ready), int'(m_phase == 3));
        check_eq("timeout_count", int'(timeout_count), m_tmo);
        check_eq("relock_count", int'(relock_count), m_rel);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Counts edges until sys_rst equals val, bounded.
    task automatic edges_until_sysrst(input bit val, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (sys_rst != val && n < 200);
    endtask

    task automatic edges_while_mmcm(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (mmcm_rst && n < 200);
    endtask

    int n;

    initial begin
        // Reset values.
        do_reset();
        check_eq("rst_state", int'(state_o), 0);
        check_eq("rst_mmcm", int'(mmcm_rst), 1);
        check_eq("rst_sys", int'(sys_rst), 1);

        // Normal start-up.
        edges_while_mmcm(n);
        check_eq("mmcm_pulse", n, int'(RstCyc));
        steps(10 - n);
        mmcm_locked = 1'b1;
        edges_until_sysrst(1'b0, n);
        check_eq("lock_to_release", n, int'(StbCyc) + 3);
        check_eq("run_state", int'(state_o), 3);
        check_eq("run_ready", int'(ready), 1);
        steps(5);

        // Lock glitch while stable.
        mmcm_locked = 1'b0;
        do_reset();
        steps(8);
        mmcm_locked = 1'b1;
        steps(5);
        mmcm_locked = 1'b0;
        steps(2);
        mmcm_locked = 1'b1;
        edges_until_sysrst(1'b0, n);
        check_eq("glitch_release", n, int'(StbCyc) + 3);
        check_eq("glitch_relock", int'(relock_count), 0);

        // Lock loss in RUN, then relock.
        mmcm_locked = 1'b0;
        edges_until_sysrst(1'b1, n);
        check_eq("loss_latency", n, 3);
        check_eq("loss_mmcm", int'(mmcm_rst), 1);
        edges_while_mmcm(n);
        check_eq("relock_pulse", n, int'(RstCyc));
        check_eq("relock_cnt", int'(relock_count), 1);
        steps(3);
        mmcm_locked = 1'b1;
        edges_until_sysrst(1'b0, n);
        check_eq("relock_release", n, int'(StbCyc) + 3);

        // Lock never rises: two timeouts.
        mmcm_locked = 1'b0;
        do_reset();
        steps(2 * (RstCyc + TmoCyc) - 1);
        check_eq("tmo_before2", int'(timeout_count), 1);
        step();
        check_eq("tmo_two", int'(timeout_count), 2);
        check_eq("tmo_mmcm", int'(mmcm_rst), 1);
        steps(20);

        // Three relocks, then reset mid-RUN.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            mmcm_locked = 1'b1;
            steps(20);
            mmcm_locked = 1'b0;
            steps(3);
        end
        mmcm_locked = 1'b1;
        steps(20);
        check_eq("three_relocks", int'(relock_count), 3);
        do_reset();
        check_eq("midrun_state", int'(state_o), 0);
        check_eq("midrun_rel", int'(relock_count), 0);
        check_eq("midrun_sys", int'(sys_rst), 1);

        // Randomized lock activity with occasional resets.
        for (int k = 0; k < 120; k++) begin
            mmcm_locked = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 24) == 0);
            step();
            rst = 1'b0;
            steps($urandom_range(0, 45));
        end

        // Saturation of relock_count.
        mmcm_locked = 1'b0;
        do_reset();
        for (int k = 0; k < 260; k++) begin
            mmcm_locked = 1'b1;
            steps(20);
            mmcm_locked = 1'b0;
            steps(3);
        end
        check_eq("relock_sat", int'(relock_count), SatMax);
        mmcm_locked = 1'b1;
        steps(20);
        mmcm_locked = 1'b0;
        steps(6);
        check_eq("relock_hold", int'(relock_count), SatMax);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
